harvard_mem_arb: RTL and testbench
==================================

// Module: harvard_mem_arb
// PURPOSE
//  Shared single-port memory for the accumulator processor, serving an instruction-fetch port and a data port.
//  Replaces bench-side memory snooping with a real req/gnt/rvalid handshake.
//  Parametrised in width, depth, read latency and arbitration mode; sits between processor core and RAM array.
// PARAMETERS
//  DATA_W     16   word width (instruction and data)
//  ADDR_W     12   address width; depth = 2**ADDR_W words (localparam DEPTH)
//  RD_LAT     2    read latency in cycles, accept edge to rvalid; legal 1..4
//  ARB_MODE   0    0 = fixed priority (data port wins), 1 = round-robin
//  INIT_FILE  ""   if non-empty, array preloaded via $readmemh at elaboration
// PORTS
//  clk         in   1       clock, all logic on rising edge
//  rst         in   1       synchronous reset, active-high
//  if_req      in   1       instruction fetch request (read only)
//  if_addr     in   ADDR_W  fetch address
//  if_gnt      out  1       fetch accepted this cycle (combinational)
//  if_rvalid   out  1       fetch data valid, one-cycle pulse
//  if_rdata    out  DATA_W  fetch data, valid only with if_rvalid
//  d_req       in   1       data port request
//  d_we        in   1       1 = write, 0 = read; sampled with d_req
//  d_addr      in   ADDR_W  data address
//  d_wdata     in   DATA_W  write data
//  d_gnt       out  1       data access accepted this cycle (combinational)
//  d_rvalid    out  1       data read valid, one-cycle pulse (never for writes)
//  d_rdata     out  DATA_W  data read result, valid only with d_rvalid
// BEHAVIOUR
//  - One array access per cycle; access is accepted on the rising edge where req && gnt.
//  - Requester holds req/addr/we/wdata stable until gnt; deasserting req before gnt is legal (request withdrawn).
//  - gnt never asserted without matching req; at most one of if_gnt/d_gnt high per cycle.
//  - Arbitration, ARB_MODE=0: d_req wins; if_gnt = if_req && !d_req.
//  - ARB_MODE=1: on conflict, grant the port not granted on the last conflict; last_winner reg resets to IF,
//    so the first conflict after reset goes to data. Single requester is always granted, and last_winner is not updated.
//  - Write: array updated at the accept edge; no rvalid; the write is visible to any read accepted on a later edge.
//  - Read: array sampled at the accept edge; result enters an RD_LAT-deep pipeline of {valid, port_id, data};
//    rvalid of the tagged port is asserted exactly RD_LAT cycles after the accept edge.
//  - Throughput: back-to-back reads, one per cycle; results return in issue order, none dropped or merged.
//  - Read accepted at edge N and write to the same address at edge N+1: the read returns the old value.
//  - Reset: pipeline valids, if_rvalid, d_rvalid and last_winner cleared; rdata outputs reset to 0.
//    Array contents are not reset.
//  - Reset mid-operation: all in-flight reads discarded; no rvalid in the cycle after rst deasserts.
//    gnt forced 0 while rst=1.
//  - Address covers full depth; no out-of-range case. No internal state machine beyond last_winner and pipeline.
// TESTING
//  1. rst=1 for 3 cycles with both reqs high -> if_gnt=d_gnt=0, rvalids=0 throughout; outputs 0 after reset.
//  2. Data write 0xBEEF @0x014, then fetch @0x014 (RD_LAT=2) -> if_rvalid 2 cycles after if_gnt, if_rdata=0xBEEF.
//  3. ARB_MODE=0, both req same cycle -> d_gnt=1, if_gnt=0; if_gnt=1 next cycle once d_req drops.
//  4. ARB_MODE=1, both req held 4 cycles -> grants D,I,D,I; rvalids return in the same order, RD_LAT apart from issue.
//  5. RD_LAT=3, fetch reads @0x000..0x003 back-to-back (preloaded 0x1000..0x1003) -> if_rvalid high 4 consecutive
//     cycles starting 3 cycles after first gnt; data 0x1000..0x1003 in order.
//  6. Read @0x020 (old 0x1111), write 0x2222 @0x020 next cycle, then rst=1 on the cycle after the read issue ->
//     no rvalid for the flushed read; repeat without rst -> read returns 0x1111, a later read returns 0x2222.

Source files
------------

// File: rtl/harvard_mem_arb.sv
// Single-port shared memory with an instruction-fetch port and a data port.
// Arbitrates one access per cycle and returns reads through a tagged RD_LAT-deep pipeline.
module harvard_mem_arb #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned ARB_MODE  = 0,
  parameter string       INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              last_d_q;
  logic              conflict;
  logic              d_wins;
  logic              rd_acc;
  logic [ADDR_W-1:0] rd_addr;

  logic [RD_LAT-1:0] pv_q;
  logic [RD_LAT-1:0] pid_q;
  logic [DATA_W-1:0] pd_q [RD_LAT];

  always_comb begin
    conflict = if_req && d_req;
    // Round-robin hands the conflict to data unless data won the previous one.
    d_wins   = (ARB_MODE == 0) || !last_d_q;
    d_gnt    = !rst && d_req && (!if_req || d_wins);
    if_gnt   = !rst && if_req && (!d_req || !d_wins);
    rd_acc   = if_gnt || (d_gnt && !d_we);
    rd_addr  = d_gnt ? d_addr : if_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_d_q <= 1'b0;
    end else if (conflict && (ARB_MODE == 1)) begin
      last_d_q <= d_gnt;
    end
  end

  always_ff @(posedge clk) begin
    if (d_gnt && d_we) begin
      mem[d_addr] <= d_wdata;
    end
  end

  // Stage 0 captures the array at the accept edge; the last stage drives the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pv_q  <= '0;
      pid_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pd_q[i] <= '0;
      end
    end else begin
      pv_q[0]  <= rd_acc;
      pid_q[0] <= d_gnt;
      pd_q[0]  <= mem[rd_addr];
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i]  <= pv_q[i-1];
        pid_q[i] <= pid_q[i-1];
        pd_q[i]  <= pd_q[i-1];
      end
    end
  end

  always_comb begin
    if_rvalid = pv_q[RD_LAT-1] && !pid_q[RD_LAT-1];
    d_rvalid  = pv_q[RD_LAT-1] && pid_q[RD_LAT-1];
    if_rdata  = pd_q[RD_LAT-1];
    d_rdata   = pd_q[RD_LAT-1];
  end

endmodule

// File: tb/tb_harvard_mem_arb.sv
// Directed bench for harvard_mem_arb: instance 0 is fixed priority with RD_LAT=2,
// instance 1 is round-robin with RD_LAT=3; reads are scored against a shadow memory.
module tb_harvard_mem_arb;

  typedef struct {
    int          due;
    logic [15:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        ir [2];
  logic        dr [2];
  logic        dw [2];
  logic [11:0] ia [2];
  logic [11:0] da [2];
  logic [15:0] wd [2];
  logic        ig [2];
  logic        dg [2];
  logic        iv [2];
  logic        dv [2];
  logic [15:0] id [2];
  logic [15:0] dd [2];

  bit          eig [2];
  bit          edg [2];
  logic [15:0] shadow [2][4096];
  exp_t        sb [4][$];
  int          cyc;
  int          checks;
  int          failures;

  harvard_mem_arb #(
    .DATA_W  (16),
    .ADDR_W  (12),
    .RD_LAT  (2),
    .ARB_MODE(0)
  ) u_dut0 (
    .clk      (clk),
    .rst      (rst),
    .if_req   (ir[0]),
    .if_addr  (ia[0]),
    .if_gnt   (ig[0]),
    .if_rvalid(iv[0]),
    .if_rdata (id[0]),
    .d_req    (dr[0]),
    .d_we     (dw[0]),
    .d_addr   (da[0]),
    .d_wdata  (wd[0]),
    .d_gnt    (dg[0]),
    .d_rvalid (dv[0]),
    .d_rdata  (dd[0])
  );

  harvard_mem_arb #(
    .DATA_W  (16),
    .ADDR_W  (12),
    .RD_LAT  (3),
    .ARB_MODE(1)
  ) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .if_req   (ir[1]),
    .if_addr  (ia[1]),
    .if_gnt   (ig[1]),
    .if_rvalid(iv[1]),
    .if_rdata (id[1]),
    .d_req    (dr[1]),
    .d_we     (dw[1]),
    .d_addr   (da[1]),
    .d_wdata  (wd[1]),
    .d_gnt    (dg[1]),
    .d_rvalid (dv[1]),
    .d_rdata  (dd[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic set(input int k, input logic i_r, input logic [11:0] i_a, input logic d_r,
                     input logic d_w, input logic [11:0] d_a, input logic [15:0] w,
                     input bit gi, input bit gd);
    ir[k]  = i_r;
    ia[k]  = i_a;
    dr[k]  = d_r;
    dw[k]  = d_w;
    da[k]  = d_a;
    wd[k]  = w;
    eig[k] = gi;
    edg[k] = gd;
  endtask

  task automatic idle(input int k);
    set(k, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic monitor();
    logic        v;
    logic [15:0] data;
    bit          exp_v;
    exp_t        e;
    for (int j = 0; j < 4; j++) begin
      v     = (j % 2 == 1) ? dv[j/2] : iv[j/2];
      data  = (j % 2 == 1) ? dd[j/2] : id[j/2];
      exp_v = (sb[j].size() > 0) && (sb[j][0].due == cyc);
      chk($sformatf("rvalid_%s%0d", (j % 2 == 1) ? "d" : "if", j / 2), v, exp_v);
      if (exp_v) begin
        e = sb[j].pop_front();
        if (v) chk($sformatf("rdata_%s%0d", (j % 2 == 1) ? "d" : "if", j / 2), data, e.data);
      end
    end
  endtask

  // Checks grants for the driven inputs, updates the model, then advances one clock.
  task automatic step();
    exp_t e;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("if_gnt%0d", k), ig[k], eig[k]);
      chk($sformatf("d_gnt%0d", k), dg[k], edg[k]);
      if (!rst) begin
        if (eig[k]) begin
          e.due  = cyc + ((k == 0) ? 2 : 3);
          e.data = shadow[k][ia[k]];
          sb[k*2].push_back(e);
        end
        if (edg[k] && dw[k]) begin
          shadow[k][da[k]] = wd[k];
        end else if (edg[k]) begin
          e.due  = cyc + ((k == 0) ? 2 : 3);
          e.data = shadow[k][da[k]];
          sb[k*2+1].push_back(e);
        end
      end
    end
    if (rst) begin
      for (int j = 0; j < 4; j++) sb[j].delete();
    end
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;

    // Reset with both requests high on both instances.
    rst = 1'b1;
    for (int k = 0; k < 2; k++) set(k, 1'b1, 12'h001, 1'b1, 1'b0, 12'h002, 16'h0, 1'b0, 1'b0);
    repeat (3) step();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_if_rdata%0d", k), id[k], 16'h0000);
      chk($sformatf("rst_d_rdata%0d", k), dd[k], 16'h0000);
    end
    rst = 1'b0;
    for (int k = 0; k < 2; k++) idle(k);
    step();

    // Write then fetch the same word.
    for (int k = 0; k < 2; k++) set(k, 1'b0, 12'h0, 1'b1, 1'b1, 12'h014, 16'hBEEF, 1'b0, 1'b1);
    step();
    for (int k = 0; k < 2; k++) set(k, 1'b1, 12'h014, 1'b0, 1'b0, 12'h0, 16'h0, 1'b1, 1'b0);
    step();
    for (int k = 0; k < 2; k++) idle(k);
    repeat (4) step();

    // Fixed priority: data wins writes and reads, fetch follows once d_req drops.
    set(0, 1'b1, 12'h050, 1'b1, 1'b1, 12'h050, 16'h5A5A, 1'b0, 1'b1);
    step();
    set(0, 1'b1, 12'h050, 1'b0, 1'b0, 12'h000, 16'h0, 1'b1, 1'b0);
    step();
    set(0, 1'b1, 12'h014, 1'b1, 1'b0, 12'h050, 16'h0, 1'b0, 1'b1);
    step();
    set(0, 1'b1, 12'h014, 1'b0, 1'b0, 12'h000, 16'h0, 1'b1, 1'b0);
    step();
    idle(0);
    repeat (4) step();

    // Round-robin: held conflict alternates D,I,D,I.
    set(1, 1'b0, 12'h0, 1'b1, 1'b1, 12'h030, 16'hA030, 1'b0, 1'b1);
    step();
    set(1, 1'b0, 12'h0, 1'b1, 1'b1, 12'h040, 16'hA040, 1'b0, 1'b1);
    step();
    for (int i = 0; i < 4; i++) begin
      set(1, 1'b1, 12'h030, 1'b1, 1'b0, 12'h040, 16'h0, (i % 2 == 1), (i % 2 == 0));
      step();
    end
    idle(1);
    repeat (5) step();

    // Back-to-back fetches of a preloaded block.
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 2; k++)
        set(k, 1'b0, 12'h0, 1'b1, 1'b1, 12'(i), 16'h1000 + 16'(i), 1'b0, 1'b1);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 2; k++) set(k, 1'b1, 12'(i), 1'b0, 1'b0, 12'h0, 16'h0, 1'b1, 1'b0);
      step();
    end
    for (int k = 0; k < 2; k++) idle(k);
    repeat (5) step();

    // Read flushed by reset; the pending write lands after reset.
    set(0, 1'b0, 12'h0, 1'b1, 1'b1, 12'h020, 16'h1111, 1'b0, 1'b1);
    step();
    set(0, 1'b0, 12'h0, 1'b1, 1'b0, 12'h020, 16'h0, 1'b0, 1'b1);
    step();
    rst = 1'b1;
    set(0, 1'b0, 12'h0, 1'b1, 1'b1, 12'h020, 16'h2222, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    set(0, 1'b0, 12'h0, 1'b1, 1'b1, 12'h020, 16'h2222, 1'b0, 1'b1);
    step();
    idle(0);
    repeat (4) step();

    // Same sequence without reset: read sees the old value, the later read the new one.
    set(0, 1'b0, 12'h0, 1'b1, 1'b1, 12'h020, 16'h1111, 1'b0, 1'b1);
    step();
    set(0, 1'b0, 12'h0, 1'b1, 1'b0, 12'h020, 16'h0, 1'b0, 1'b1);
    step();
    set(0, 1'b0, 12'h0, 1'b1, 1'b1, 12'h020, 16'h2222, 1'b0, 1'b1);
    step();
    set(0, 1'b0, 12'h0, 1'b1, 1'b0, 12'h020, 16'h0, 1'b0, 1'b1);
    step();
    idle(0);
    repeat (4) step();

    for (int j = 0; j < 4; j++) chk($sformatf("sb_drained%0d", j), sb[j].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
